// File: rtl/controle_tentativas.sv
// controle_tentativas: ENTER-button attempt controller for the bomb game.
// Debounces the raw button, accepts one attempt per press, counts wrong
// attempts, requests time penalties from the timer and enforces a lockout.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | no phase running, presses ignored
// PRONTO     | waiting for a press; accepts and grades attempts
// PENALIDADE | pen_req raised, waiting for the timer's pen_ack
// BLOQUEIO   | lockout window after a penalty, counting tick_1ms strobes
// ESGOTADO   | attempts exhausted, sticky until reset
module controle_tentativas #(
  parameter int DEBOUNCE_MS = 20,
  parameter int LOCKOUT_MS  = 1000,
  parameter int MAX_TENT    = 7,
  parameter int PENALTY_DS  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       fase_ativa,
  input  logic       enter_raw,
  input  logic       tentativa_ok,
  output logic       accept,
  output logic       erro,
  output logic       pen_req,
  input  logic       pen_ack,
  output logic [7:0] pen_ds,
  output logic       bloqueado,
  output logic [3:0] tent_restantes,
  output logic       esgotado
);

  typedef enum logic [2:0] {
    IDLE,
    PRONTO,
    PENALIDADE,
    BLOQUEIO,
    ESGOTADO
  } state_t;

  localparam logic [15:0] DEB_LIMIT  = 16'(DEBOUNCE_MS);
  localparam logic [15:0] LOCK_INIT  = 16'(LOCKOUT_MS);
  localparam logic [3:0]  TENT_INIT  = 4'(MAX_TENT);
  localparam logic [11:0] PEN_BASE   = 12'(PENALTY_DS);

  state_t      state, state_nx;
  logic        sync_q1, sync;
  logic        debounced, debounced_q, press_evt;
  logic [15:0] deb_cnt;
  logic [15:0] lock_cnt;
  logic [3:0]  erros;
  logic [3:0]  erros_nx;
  logic [11:0] pen_prod;
  logic [7:0]  pen_sat;
  logic        wrong;
  logic        lock_done;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= enter_raw;
      sync    <= sync_q1;
    end
  end

  // Debounce: the synchronized level must differ from the held level for
  // DEBOUNCE_MS consecutive ms strobes before it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt   <= '0;
      debounced <= 1'b0;
    end else if (sync == debounced) begin
      deb_cnt <= '0;
    end else if (tick_1ms) begin
      if (deb_cnt + 16'd1 >= DEB_LIMIT) begin
        debounced <= sync;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

  // Registered rising-edge detect: one press event per debounced press.
  always_ff @(posedge clk) begin
    if (reset) begin
      debounced_q <= 1'b0;
      press_evt   <= 1'b0;
    end else begin
      debounced_q <= debounced;
      press_evt   <= debounced & ~debounced_q;
    end
  end

  // Penalty grows with the wrong-attempt count and saturates at 255 ds.
  always_comb begin
    erros_nx = erros + 4'd1;
    pen_prod = PEN_BASE * {8'd0, erros_nx};
    pen_sat  = (pen_prod > 12'd255) ? 8'hFF : pen_prod[7:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and attempt grading; fase_ativa loss aborts everything
  // except the sticky exhausted state.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    wrong     = 1'b0;
    lock_done = tick_1ms && (lock_cnt == 16'd1);
    case (state)
      IDLE: begin
        if (fase_ativa) state_nx = PRONTO;
      end
      PRONTO: begin
        if (!fase_ativa) begin
          state_nx = IDLE;
        end else if (press_evt) begin
          accept = 1'b1;
          if (!tentativa_ok) begin
            wrong    = 1'b1;
            state_nx = (tent_restantes == 4'd1) ? ESGOTADO : PENALIDADE;
          end
        end
      end
      PENALIDADE: begin
        if (!fase_ativa)  state_nx = IDLE;
        else if (pen_ack) state_nx = BLOQUEIO;
      end
      BLOQUEIO: begin
        if (!fase_ativa)    state_nx = IDLE;
        else if (lock_done) state_nx = PRONTO;
      end
      ESGOTADO: state_nx = ESGOTADO;
      default:  state_nx = IDLE;
    endcase
  end

  // pen_req is gated by fase_ativa so an aborted penalty drops at once.
  always_comb begin
    pen_req   = (state == PENALIDADE) && fase_ativa;
    bloqueado = (state == PENALIDADE) || (state == BLOQUEIO);
    esgotado  = (state == ESGOTADO);
  end

  // Attempt bookkeeping, penalty amount and lockout down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      erro           <= 1'b0;
      erros          <= '0;
      tent_restantes <= TENT_INIT;
      pen_ds         <= '0;
      lock_cnt       <= '0;
    end else begin
      erro <= wrong;
      if (wrong) begin
        erros          <= erros_nx;
        tent_restantes <= tent_restantes - 4'd1;
        if (state_nx == PENALIDADE) pen_ds <= pen_sat;
      end
      if (state != BLOQUEIO)  lock_cnt <= LOCK_INIT;
      else if (tick_1ms)      lock_cnt <= lock_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_controle_tentativas.sv
// Directed bench for controle_tentativas: debounce, grading, penalty
// handshake, lockout, exhaustion, saturation, abort and reset.
module tb_controle_tentativas;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       fase_ativa = 1'b0;
  logic       enter_raw = 1'b0;
  logic       tentativa_ok = 1'b1;
  logic       pen_ack = 1'b0;

  logic       accept, erro, pen_req, bloqueado, esgotado;
  logic [7:0] pen_ds;
  logic [3:0] tent_restantes;

  logic       accept2, erro2, pen_req2, bloqueado2, esgotado2;
  logic [7:0] pen_ds2;
  logic [3:0] tent_restantes2;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;

  controle_tentativas #(
    .DEBOUNCE_MS(2), .LOCKOUT_MS(3), .MAX_TENT(3), .PENALTY_DS(50)
  ) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .fase_ativa(fase_ativa),
    .enter_raw(enter_raw), .tentativa_ok(tentativa_ok), .accept(accept),
    .erro(erro), .pen_req(pen_req), .pen_ack(pen_ack), .pen_ds(pen_ds),
    .bloqueado(bloqueado), .tent_restantes(tent_restantes), .esgotado(esgotado)
  );

  controle_tentativas #(
    .DEBOUNCE_MS(2), .LOCKOUT_MS(3), .MAX_TENT(3), .PENALTY_DS(200)
  ) dut_sat (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .fase_ativa(fase_ativa),
    .enter_raw(enter_raw), .tentativa_ok(tentativa_ok), .accept(accept2),
    .erro(erro2), .pen_req(pen_req2), .pen_ack(pen_ack), .pen_ds(pen_ds2),
    .bloqueado(bloqueado2), .tent_restantes(tent_restantes2), .esgotado(esgotado2)
  );

  always #5 clk = ~clk;

  // One-cycle tick every 10 clocks
  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 tick_1ms = 1'b1;
      @(posedge clk);
      #1 tick_1ms = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (accept) acc_cnt++;
    if (accept && (erro || bloqueado)) begin
      bad++;
      $error("FAIL accept_excl observed accept=%0d erro=%0d bloqueado=%0d expected accept alone",
             accept, erro, bloqueado);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (accept) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, int'(got), 1);
  endtask

  task automatic release_button();
    enter_raw = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic ack_and_lockout(input string tag);
    int  ticks = 0;
    bit  found = 1'b0;
    pen_ack = 1'b1;
    @(negedge clk);
    pen_ack = 1'b0;
    chk({tag, "_req_low"}, int'(pen_req), 0);
    chk({tag, "_blq_high"}, int'(bloqueado), 1);
    for (int i = 0; i < 80; i++) begin
      if (!bloqueado) begin
        found = 1'b1;
        break;
      end
      if (tick_1ms) ticks++;
      @(negedge clk);
    end
    chk({tag, "_lock_end"}, int'(found), 1);
    chk({tag, "_lock_ticks"}, ticks, 3);
  endtask

  initial begin
    int a0;
    bit stable;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_accept", int'(accept), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_pen_req", int'(pen_req), 0);
    chk("rst_pen_ds", int'(pen_ds), 0);
    chk("rst_bloqueado", int'(bloqueado), 0);
    chk("rst_tent", int'(tent_restantes), 3);
    chk("rst_esgotado", int'(esgotado), 0);

    // Bounce with a correct answer pending: no accept while bouncing
    fase_ativa   = 1'b1;
    tentativa_ok = 1'b1;
    repeat (4) @(negedge clk);
    a0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      enter_raw = ~enter_raw;
      repeat (5) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("bounce_no_accept", acc_cnt - a0, 0);
    enter_raw = 1'b1;
    wait_accept("bounce_accept");
    @(negedge clk);
    chk("ok_erro", int'(erro), 0);
    chk("ok_tent", int'(tent_restantes), 3);
    chk("ok_pen_req", int'(pen_req), 0);
    repeat (40) @(negedge clk);
    chk("bounce_one_accept", acc_cnt - a0, 1);
    release_button();

    // Second correct attempt, clean press
    a0 = acc_cnt;
    enter_raw = 1'b1;
    wait_accept("ok2_accept");
    @(negedge clk);
    chk("ok2_tent", int'(tent_restantes), 3);
    chk("ok2_bloq", int'(bloqueado), 0);
    release_button();
    chk("ok2_one_accept", acc_cnt - a0, 1);

    // First wrong attempt: penalty 50 (200 on the saturating instance)
    tentativa_ok = 1'b0;
    enter_raw = 1'b1;
    wait_accept("w1_accept");
    @(negedge clk);
    chk("w1_erro", int'(erro), 1);
    chk("w1_tent", int'(tent_restantes), 2);
    chk("w1_pen_req", int'(pen_req), 1);
    chk("w1_pen_ds", int'(pen_ds), 50);
    chk("w1_pen_ds_sat", int'(pen_ds2), 200);
    chk("w1_bloq", int'(bloqueado), 1);
    enter_raw = 1'b0;
    // Hold ack low; a press made during the penalty must be discarded
    a0 = acc_cnt;
    stable = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 40) enter_raw = 1'b1;
      @(negedge clk);
      if (pen_ds !== 8'd50 || pen_req !== 1'b1) stable = 1'b0;
    end
    chk("w1_pen_hold", int'(stable), 1);
    chk("w1_erro_pulse", int'(erro), 0);
    ack_and_lockout("w1");
    repeat (20) @(negedge clk);
    chk("w1_no_queued_accept", acc_cnt - a0, 0);
    release_button();

    // Second wrong attempt: escalation and saturation
    enter_raw = 1'b1;
    wait_accept("w2_accept");
    @(negedge clk);
    chk("w2_tent", int'(tent_restantes), 1);
    chk("w2_pen_ds", int'(pen_ds), 100);
    chk("w2_pen_ds_sat", int'(pen_ds2), 255);
    chk("w2_pen_req", int'(pen_req), 1);
    enter_raw = 1'b0;
    repeat (5) @(negedge clk);
    ack_and_lockout("w2");
    release_button();

    // Third wrong attempt: exhaustion without penalty
    enter_raw = 1'b1;
    wait_accept("w3_accept");
    @(negedge clk);
    chk("w3_erro", int'(erro), 1);
    chk("w3_tent", int'(tent_restantes), 0);
    chk("w3_esgotado", int'(esgotado), 1);
    chk("w3_pen_req", int'(pen_req), 0);
    chk("w3_bloq", int'(bloqueado), 0);
    release_button();
    a0 = acc_cnt;
    enter_raw = 1'b1;
    repeat (60) @(negedge clk);
    chk("esg_no_accept", acc_cnt - a0, 0);
    chk("esg_sticky", int'(esgotado), 1);
    release_button();

    // Reset clears exhaustion
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_esgotado", int'(esgotado), 0);
    chk("rst2_tent", int'(tent_restantes), 3);
    repeat (4) @(negedge clk);

    // Abort a pending penalty by dropping fase_ativa
    enter_raw = 1'b1;
    wait_accept("ab_accept");
    @(negedge clk);
    chk("ab_pen_req", int'(pen_req), 1);
    chk("ab_pen_ds", int'(pen_ds), 50);
    enter_raw = 1'b0;
    fase_ativa = 1'b0;
    @(negedge clk);
    chk("ab_req_drop", int'(pen_req), 0);
    @(negedge clk);
    chk("ab_idle_bloq", int'(bloqueado), 0);
    fase_ativa = 1'b1;
    repeat (40) @(negedge clk);
    chk("ab_no_reissue", int'(pen_req), 0);
    chk("ab_tent", int'(tent_restantes), 2);

    // Reset while in lockout
    enter_raw = 1'b1;
    wait_accept("rb_accept");
    @(negedge clk);
    chk("rb_pen_ds", int'(pen_ds), 100);
    enter_raw = 1'b0;
    pen_ack = 1'b1;
    @(negedge clk);
    pen_ack = 1'b0;
    @(negedge clk);
    chk("rb_in_lockout", int'(bloqueado), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rb_accept0", int'(accept), 0);
    chk("rb_erro0", int'(erro), 0);
    chk("rb_pen_req0", int'(pen_req), 0);
    chk("rb_pen_ds0", int'(pen_ds), 0);
    chk("rb_bloq0", int'(bloqueado), 0);
    chk("rb_tent3", int'(tent_restantes), 3);
    chk("rb_esg0", int'(esgotado), 0);
    chk("rb_tent3_sat", int'(tent_restantes2), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
